// File: rtl/reg_wr_decoder.sv
// Register write-enable decoder: turns burst or broadcast write requests into
// registered per-register write enables, one beat per clock.
module reg_wr_decoder #(
    parameter int ADDR_W     = 4,
    parameter bit PROTECT_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [ADDR_W-1:0]        req_len,
    input  logic                     req_mode,
    input  logic                     abort,
    output logic [(1<<ADDR_W)-1:0]   wr_en,
    output logic [ADDR_W-1:0]        wr_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int NREGS = 1 << ADDR_W;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   rem_reg, rem_next;
    logic [NREGS-1:0]    wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0]   wr_idx_reg, wr_idx_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic [ADDR_W-1:0]   step_idx;

    // A beat aimed at a protected r0 keeps its slot but writes nothing.
    function automatic logic r0_blocked(input logic [ADDR_W-1:0] idx);
        return PROTECT_R0 && (idx == '0);
    endfunction

    function automatic logic [NREGS-1:0] beat_en(input logic [ADDR_W-1:0] idx);
        return r0_blocked(idx) ? '0 : (NREGS'(1) << idx);
    endfunction

    // Natural ADDR_W-bit overflow gives the NREGS-1 -> 0 wrap.
    assign step_idx = wr_idx_reg + ADDR_W'(1);

    always_comb begin
        state_next  = state_reg;
        rem_next    = rem_reg;
        wr_en_next  = '0;
        wr_idx_next = wr_idx_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = BURST;
                    if (req_mode) begin
                        wr_en_next  = {{(NREGS-1){1'b1}}, ~PROTECT_R0};
                        wr_idx_next = '0;
                        rem_next    = '0;
                        done_next   = 1'b1;
                    end else begin
                        wr_en_next  = beat_en(req_addr);
                        wr_idx_next = req_addr;
                        err_next    = r0_blocked(req_addr);
                        rem_next    = req_len;
                        done_next   = (req_len == '0);
                    end
                end
            end
            BURST: begin
                // rem_reg counts beats still owed after the one now on the outputs.
                if (abort || rem_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    wr_en_next  = beat_en(step_idx);
                    wr_idx_next = step_idx;
                    err_next    = r0_blocked(step_idx);
                    rem_next    = rem_reg - ADDR_W'(1);
                    done_next   = (rem_reg == ADDR_W'(1));
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rem_reg    <= '0;
            wr_en_reg  <= '0;
            wr_idx_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rem_reg    <= rem_next;
            wr_en_reg  <= wr_en_next;
            wr_idx_reg <= wr_idx_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg == BURST);
    assign wr_en     = wr_en_reg;
    assign wr_idx    = wr_idx_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule
